// File: rtl/w_grf.sv
// -----------------------------------------------------------------------------
// w_grf -- write-back stage general register file
//
// Purpose:
//   Forms the final write-back value (ALU result, extended load data, link
//   address or zero), commits it to a 31-entry register file ($0 hard-wired
//   to zero), serves two zero-latency decode-stage read ports with
//   write-before-read bypass, and produces a one-cycle-delayed commit trace
//   plus a retired-instruction counter.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   W_PC, W_inStr              PC and instruction word in W (zero = bubble)
//   W_writeReg_NUM             destination register number
//   W_aluResult                ALU result; [1:0] is the load byte offset
//   W_dataOUT                  aligned memory word read in M
//   W_PC8                      link value for jal/jalr
//   W_regWrite                 instruction writes the register file
//   W_wdSel                    0 ALU, 1 load, 2 PC8, 3 zero
//   W_loadType                 0 word, 1 lbu, 2 lb, 3 lhu, 4 lh, 5-7 word
//   D_rs_NUM, D_rt_NUM         decode-stage read addresses
//   D_rs_DATA, D_rt_DATA       decode-stage read data
//   W_writeData, W_writeEn     final write value and effective write enable
//   trace_valid/PC/NUM/DATA    register write committed on the previous edge
//   retire_cnt                 count of retired non-bubble instructions
// -----------------------------------------------------------------------------
module w_grf (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_PC,
    input  logic [31:0] W_inStr,
    input  logic [4:0]  W_writeReg_NUM,
    input  logic [31:0] W_aluResult,
    input  logic [31:0] W_dataOUT,
    input  logic [31:0] W_PC8,
    input  logic        W_regWrite,
    input  logic [1:0]  W_wdSel,
    input  logic [2:0]  W_loadType,
    input  logic [4:0]  D_rs_NUM,
    input  logic [4:0]  D_rt_NUM,
    output logic [31:0] D_rs_DATA,
    output logic [31:0] D_rt_DATA,
    output logic [31:0] W_writeData,
    output logic        W_writeEn,
    output logic        trace_valid,
    output logic [31:0] trace_PC,
    output logic [31:0] trace_DATA,
    output logic [4:0]  trace_NUM,
    output logic [31:0] retire_cnt
);

    // Register storage; $0 has no entry and is synthesised as constant zero.
    logic [31:0] regs_q [1:31];

    logic        trace_valid_q, trace_valid_d;
    logic [31:0] trace_pc_q, trace_pc_d;
    logic [31:0] trace_data_q, trace_data_d;
    logic [4:0]  trace_num_q, trace_num_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    logic [31:0] load_data_s;
    logic [31:0] rs_stored_s;
    logic [31:0] rt_stored_s;

    // Select the addressed byte/halfword and extend it. Halfword selection
    // looks only at offset bit 1; offset bit 0 is ignored for halfwords.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  ltype);
        logic [7:0]  b_v;
        logic [15:0] h_v;
        case (off)
            2'd0:    b_v = word[7:0];
            2'd1:    b_v = word[15:8];
            2'd2:    b_v = word[23:16];
            2'd3:    b_v = word[31:24];
            default: b_v = word[7:0];
        endcase
        if (off[1]) begin
            h_v = word[31:16];
        end else begin
            h_v = word[15:0];
        end
        case (ltype)
            3'd1:    load_extend = {24'h000000, b_v};
            3'd2:    load_extend = {{24{b_v[7]}}, b_v};
            3'd3:    load_extend = {16'h0000, h_v};
            3'd4:    load_extend = {{16{h_v[15]}}, h_v};
            default: load_extend = word;
        endcase
    endfunction

    // Read-port priority: $0 first, then bypass of the in-flight write,
    // then the stored value.
    function automatic logic [31:0] read_mux(input logic [4:0]  num,
                                             input logic        wen,
                                             input logic [4:0]  wnum,
                                             input logic [31:0] wdata,
                                             input logic [31:0] stored);
        if (num == 5'd0) begin
            read_mux = 32'h0000_0000;
        end else if (wen && (num == wnum)) begin
            read_mux = wdata;
        end else begin
            read_mux = stored;
        end
    endfunction

    // Write-back data selection and effective write enable.
    always_comb begin
        load_data_s = load_extend(W_dataOUT, W_aluResult[1:0], W_loadType);
        case (W_wdSel)
            2'd0:    W_writeData = W_aluResult;
            2'd1:    W_writeData = load_data_s;
            2'd2:    W_writeData = W_PC8;
            2'd3:    W_writeData = 32'h0000_0000;
            default: W_writeData = 32'h0000_0000;
        endcase
        W_writeEn = W_regWrite && (W_writeReg_NUM != 5'd0);
    end

    // Stored-value lookup for both read ports ($0 has no storage entry).
    always_comb begin
        if (D_rs_NUM == 5'd0) begin
            rs_stored_s = 32'h0000_0000;
        end else begin
            rs_stored_s = regs_q[D_rs_NUM];
        end
        if (D_rt_NUM == 5'd0) begin
            rt_stored_s = 32'h0000_0000;
        end else begin
            rt_stored_s = regs_q[D_rt_NUM];
        end
    end

    // Zero-latency read ports with write-before-read bypass.
    always_comb begin
        D_rs_DATA = read_mux(D_rs_NUM, W_writeEn, W_writeReg_NUM, W_writeData, rs_stored_s);
        D_rt_DATA = read_mux(D_rt_NUM, W_writeEn, W_writeReg_NUM, W_writeData, rt_stored_s);
    end

    // Next-state for trace (holds fields when nothing commits) and counter.
    always_comb begin
        trace_valid_d = W_writeEn;
        if (W_writeEn) begin
            trace_pc_d   = W_PC;
            trace_num_d  = W_writeReg_NUM;
            trace_data_d = W_writeData;
        end else begin
            trace_pc_d   = trace_pc_q;
            trace_num_d  = trace_num_q;
            trace_data_d = trace_data_q;
        end
        if (W_inStr != 32'h0000_0000) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Register file commit; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else if (W_writeEn) begin
            regs_q[W_writeReg_NUM] <= W_writeData;
        end
    end

    // Trace and retire-counter state.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= 32'h0000_0000;
            trace_num_q   <= 5'd0;
            trace_data_q  <= 32'h0000_0000;
            retire_cnt_q  <= 32'h0000_0000;
        end else begin
            trace_valid_q <= trace_valid_d;
            trace_pc_q    <= trace_pc_d;
            trace_num_q   <= trace_num_d;
            trace_data_q  <= trace_data_d;
            retire_cnt_q  <= retire_cnt_d;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_PC    = trace_pc_q;
    assign trace_NUM   = trace_num_q;
    assign trace_DATA  = trace_data_q;
    assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_w_grf.sv
// -----------------------------------------------------------------------------
// tb_w_grf -- self-checking bench for w_grf
//
// A behavioural reference (register array, counter, trace fields) is updated
// from the architectural rules on every rising edge; the DUT is compared
// against it after each input change and after each edge.
// -----------------------------------------------------------------------------
module tb_w_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] W_PC, W_inStr, W_aluResult, W_dataOUT, W_PC8;
    logic [4:0]  W_writeReg_NUM, D_rs_NUM, D_rt_NUM;
    logic        W_regWrite;
    logic [1:0]  W_wdSel;
    logic [2:0]  W_loadType;
    logic [31:0] D_rs_DATA, D_rt_DATA, W_writeData, trace_PC, trace_DATA, retire_cnt;
    logic        W_writeEn, trace_valid;
    logic [4:0]  trace_NUM;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt, m_tpc, m_tdata;
    logic [4:0]  m_tnum;
    logic        m_tv;

    always #5 clk = ~clk;

    w_grf dut (
        .clk(clk), .reset(reset), .W_PC(W_PC), .W_inStr(W_inStr),
        .W_writeReg_NUM(W_writeReg_NUM), .W_aluResult(W_aluResult),
        .W_dataOUT(W_dataOUT), .W_PC8(W_PC8), .W_regWrite(W_regWrite),
        .W_wdSel(W_wdSel), .W_loadType(W_loadType), .D_rs_NUM(D_rs_NUM),
        .D_rt_NUM(D_rt_NUM), .D_rs_DATA(D_rs_DATA), .D_rt_DATA(D_rt_DATA),
        .W_writeData(W_writeData), .W_writeEn(W_writeEn),
        .trace_valid(trace_valid), .trace_PC(trace_PC), .trace_DATA(trace_DATA),
        .trace_NUM(trace_NUM), .retire_cnt(retire_cnt)
    );

    // Expected load value, computed with shifts/masks and arithmetic extension.
    function automatic logic [31:0] m_load();
        logic [31:0] b = (W_dataOUT >> (8 * W_aluResult[1:0])) & 32'h0000_00FF;
        logic [31:0] h = W_aluResult[1] ? (W_dataOUT >> 16) : (W_dataOUT & 32'h0000_FFFF);
        case (W_loadType)
            3'd1:    return b;
            3'd2:    return (b >= 32'd128)   ? (b + 32'hFFFF_FF00) : b;
            3'd3:    return h;
            3'd4:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
            default: return W_dataOUT;
        endcase
    endfunction

    function automatic logic [31:0] m_wd();
        case (W_wdSel)
            2'd0:    return W_aluResult;
            2'd1:    return m_load();
            2'd2:    return W_PC8;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic m_we();
        return W_regWrite && (W_writeReg_NUM != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] num);
        if (num == 5'd0) return 32'h0000_0000;
        if (m_we() && num == W_writeReg_NUM) return m_wd();
        return m_regs[num];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] wn, input logic [31:0] alu, input logic [31:0] dout,
                         input logic [31:0] pc8, input logic rw, input logic [1:0] sel,
                         input logic [2:0] lt, input logic [4:0] rs, input logic [4:0] rt);
        reset = rst; W_PC = pc; W_inStr = instr; W_writeReg_NUM = wn; W_aluResult = alu;
        W_dataOUT = dout; W_PC8 = pc8; W_regWrite = rw; W_wdSel = sel; W_loadType = lt;
        D_rs_NUM = rs; D_rt_NUM = rt;
    endtask

    // Combinational outputs after inputs settle.
    task automatic comb_check();
        #1;
        chk("writeData", W_writeData, m_wd());
        chk("writeEn", {31'h0, W_writeEn}, {31'h0, m_we()});
        chk("rs_data", D_rs_DATA, m_read(D_rs_NUM));
        chk("rt_data", D_rt_DATA, m_read(D_rt_NUM));
    endtask

    // One rising edge: update reference, then compare registered outputs.
    task automatic edge_step();
        logic        we;
        logic [31:0] wd;
        we = m_we();
        wd = m_wd();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0000_0000;
            m_cnt = 32'h0; m_tv = 1'b0; m_tpc = 32'h0; m_tnum = 5'd0; m_tdata = 32'h0;
        end else begin
            if (we) begin
                m_regs[W_writeReg_NUM] = wd;
                m_tpc = W_PC; m_tnum = W_writeReg_NUM; m_tdata = wd;
            end
            m_tv = we;
            if (W_inStr != 32'h0) m_cnt = m_cnt + 32'd1;
        end
        #1;
        chk("trace_valid", {31'h0, trace_valid}, {31'h0, m_tv});
        chk("trace_PC", trace_PC, m_tpc);
        chk("trace_NUM", {27'h0, trace_NUM}, {27'h0, m_tnum});
        chk("trace_DATA", trace_DATA, m_tdata);
        chk("retire_cnt", retire_cnt, m_cnt);
        @(negedge clk);
    endtask

    logic [1:0]  ld_off [5];
    logic [2:0]  ld_typ [5];
    logic [31:0] ld_exp [5];

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0; m_tv = 1'b0; m_tpc = 32'h0; m_tnum = 5'd0; m_tdata = 32'h0;

        // Reset state
        apply(1'b1, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 5'd0, 5'd0);
        edge_step();
        edge_step();
        chk("reset_cnt", retire_cnt, 32'h0);

        // Write $5 with bypass, then stored read
        apply(1'b0, 32'h0000_1000, 32'h0000_0001, 5'd5, 32'h1234_ABCD, 32'h0, 32'h0,
              1'b1, 2'd0, 3'd0, 5'd5, 5'd0);
        comb_check();
        chk("bypass_rs5", D_rs_DATA, 32'h1234_ABCD);
        edge_step();
        chk("trace_valid_w5", {31'h0, trace_valid}, 32'h1);
        chk("trace_num_w5", {27'h0, trace_NUM}, 32'h5);
        apply(1'b0, 32'h0000_1004, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 5'd5, 5'd5);
        comb_check();
        chk("stored_rs5", D_rs_DATA, 32'h1234_ABCD);
        edge_step();

        // Write to $0 is suppressed
        apply(1'b0, 32'h0000_1008, 32'h0000_0002, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0,
              1'b1, 2'd0, 3'd0, 5'd0, 5'd0);
        comb_check();
        chk("r0_we", {31'h0, W_writeEn}, 32'h0);
        chk("r0_read", D_rs_DATA, 32'h0);
        edge_step();
        chk("r0_trace", {31'h0, trace_valid}, 32'h0);

        // Load extension cases
        ld_off = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd1};
        ld_typ = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd0};
        ld_exp = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 32'h0000_2000 + 32'(i * 4), 32'h0000_0003, 5'd3, {30'h0, ld_off[i]},
                  32'h80FF_7F01, 32'h0, 1'b1, 2'd1, ld_typ[i], 5'd3, 5'd5);
            comb_check();
            chk($sformatf("load_%0d", i), W_writeData, ld_exp[i]);
            edge_step();
        end

        // jal link write to $31
        apply(1'b0, 32'h0000_3000, 32'h0C00_0000, 5'd31, 32'h0, 32'h0, 32'h0000_3008,
              1'b1, 2'd2, 3'd0, 5'd0, 5'd0);
        comb_check();
        edge_step();
        apply(1'b0, 32'h0000_3004, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd3, 3'd0, 5'd31, 5'd3);
        comb_check();
        chk("jal_r31", D_rs_DATA, 32'h0000_3008);
        chk("sel3_zero", W_writeData, 32'h0);
        edge_step();

        // Both ports addressing the register being written
        apply(1'b0, 32'h0000_3008, 32'h1, 5'd9, 32'hCAFE_0009, 32'h0, 32'h0,
              1'b1, 2'd0, 3'd0, 5'd9, 5'd9);
        comb_check();
        chk("dual_byp_rs", D_rs_DATA, 32'hCAFE_0009);
        chk("dual_byp_rt", D_rt_DATA, 32'hCAFE_0009);
        edge_step();

        // Counter wrap: preload near the top, then count through the wrap
        force dut.retire_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        apply(1'b0, 32'h0000_4000, 32'h0000_0001, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 5'd0, 5'd0);
        edge_step();
        chk("cnt_max", retire_cnt, 32'hFFFF_FFFF);
        edge_step();
        chk("cnt_wrap", retire_cnt, 32'h0);
        apply(1'b0, 32'h0000_4004, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 5'd0, 5'd0);
        edge_step();
        chk("cnt_bubble", retire_cnt, 32'h0);

        // Reset coinciding with a write to $7; bypass stays live during reset
        apply(1'b0, 32'h0000_5000, 32'h1, 5'd7, 32'h0000_0777, 32'h0, 32'h0,
              1'b1, 2'd0, 3'd0, 5'd7, 5'd0);
        edge_step();
        apply(1'b1, 32'h0000_5004, 32'h1, 5'd7, 32'h0000_7777, 32'h0, 32'h0,
              1'b1, 2'd0, 3'd0, 5'd7, 5'd7);
        comb_check();
        chk("rst_bypass", D_rs_DATA, 32'h0000_7777);
        edge_step();
        chk("rst_tv", {31'h0, trace_valid}, 32'h0);
        chk("rst_cnt", retire_cnt, 32'h0);
        apply(1'b0, 32'h0000_5008, 32'h1, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 5'd7, 5'd0);
        comb_check();
        chk("rst_r7", D_rs_DATA, 32'h0);
        edge_step();
        chk("post_rst_cnt", retire_cnt, 32'h1);

        // Randomized traffic against the reference
        for (int n = 0; n < 400; n++) begin
            reset          = ($urandom_range(0, 29) == 0);
            W_PC           = $urandom;
            W_inStr        = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            W_writeReg_NUM = 5'($urandom_range(0, 31));
            W_aluResult    = $urandom;
            W_dataOUT      = $urandom;
            W_PC8          = $urandom;
            W_regWrite     = 1'($urandom_range(0, 1));
            W_wdSel        = 2'($urandom_range(0, 3));
            W_loadType     = 3'($urandom_range(0, 7));
            D_rs_NUM       = ($urandom_range(0, 1) == 0) ? W_writeReg_NUM : 5'($urandom_range(0, 31));
            D_rt_NUM       = ($urandom_range(0, 1) == 0) ? W_writeReg_NUM : 5'($urandom_range(0, 31));
            comb_check();
            edge_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
